ov7670_config_sequencer: RTL and testbench



---
 rtl/ov7670_pkg.sv | 25 ++
 rtl/cfg_delay_counter.sv | 38 +++
 rtl/ov7670_config_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_ov7670_config_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared constants for the OV7670 configuration path: table markers, FSM state codes,
// default timing and a counter-width helper.
package ov7670_pkg;

  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFF0;

  localparam int DELAY_CYCLES_DEF   = 250000;
  localparam int TIMEOUT_CYCLES_DEF = 65535;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_SEND   = 3'd3;
  localparam state_t S_DELAY  = 3'd4;
  localparam state_t S_FIN    = 3'd5;

  // Width needed to hold values 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cfg_delay_counter.sv
// Loadable down-counter with a zero flag; serves both the table delay and the SEND timeout.
// Latency: load/decrement visible the cycle after the strobe. Backpressure: none.
// The count saturates at zero so a stray decrement never wraps.
module cfg_delay_counter
  import ov7670_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM and issues register writes to the SCCB master; CFG_SEQ_TIMEOUT_EN adds a SEND abort.
// Latency: start to first cmd_valid 3 cycles, accept to next cmd_valid 3 cycles.
// Backpressure: a command is held stable in SEND until cmd_ready (or timeout when enabled).
module ov7670_config_sequencer
  import ov7670_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DELAY_CYCLES   = DELAY_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_dout,
  output logic              cmd_valid,
  output logic [7:0]        cmd_reg,
  output logic [7:0]        cmd_data,
  input  logic              cmd_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                DW        = cnt_w(DELAY_CYCLES);
  localparam logic [DW-1:0]     DLY_LOAD  = DW'(DELAY_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        cmd_reg_q, cmd_reg_d;
  logic [7:0]        cmd_data_q, cmd_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              advance;
  logic              dly_load, dly_dec, dly_zero;

  cfg_delay_counter #(.W(DW)) u_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (dly_load),
    .load_val_i (DLY_LOAD),
    .dec_i      (dly_dec),
    .zero_o     (dly_zero)
  );

`ifdef CFG_SEQ_TIMEOUT_EN
  localparam int            TW      = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic to_load, to_dec, to_zero;

  // Reloaded on every SEND entry; reaching zero marks the last allowed SEND cycle.
  cfg_delay_counter #(.W(TW)) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (to_load),
    .load_val_i (TO_LOAD),
    .dec_i      (to_dec),
    .zero_o     (to_zero)
  );
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_reg_d   = cmd_reg_q;
    cmd_data_d  = cmd_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    advance     = 1'b0;
    dly_load    = 1'b0;
    dly_dec     = 1'b0;
`ifdef CFG_SEQ_TIMEOUT_EN
    to_load     = 1'b0;
    to_dec      = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_dout == CFG_END) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else if (rom_dout == CFG_DELAY) begin
          dly_load = 1'b1;
          state_d  = S_DELAY;
        end else begin
          cmd_reg_d   = rom_dout[15:8];
          cmd_data_d  = rom_dout[7:0];
          cmd_valid_d = 1'b1;
          state_d     = S_SEND;
`ifdef CFG_SEQ_TIMEOUT_EN
          to_load     = 1'b1;
`endif
        end
      end
      S_SEND: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          advance     = 1'b1;
        end
`ifdef CFG_SEQ_TIMEOUT_EN
        else if (to_zero) begin
          cmd_valid_d = 1'b0;
          err_d       = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_FIN;
        end else begin
          to_dec = 1'b1;
        end
`endif
      end
      S_DELAY: begin
        if (dly_zero) begin
          advance = 1'b1;
        end else begin
          dly_dec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The last ROM slot ends the run even without an end marker; the address never wraps.
    if (advance) begin
      if (addr_q == ADDR_LAST) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_FIN;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_reg_q   <= '0;
      cmd_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_reg_q   <= cmd_reg_d;
      cmd_data_q  <= cmd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rom_addr  = addr_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_reg   = cmd_reg_q;
  assign cmd_data  = cmd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: ADDR_W=2, DELAY_CYCLES=4, TIMEOUT_CYCLES=8; timeout case runs when CFG_SEQ_TIMEOUT_EN is defined.
module tb_ov7670_config_sequencer;

  localparam int D_CYC   = 4;
  localparam int LAST    = 3;
`ifdef CFG_SEQ_TIMEOUT_EN
  localparam int HOLD    = 5;
`else
  localparam int HOLD    = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        cmd_valid;
  logic [7:0]  cmd_reg;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  ov7670_config_sequencer #(
    .ADDR_W         (2),
    .DELAY_CYCLES   (D_CYC),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .cmd_valid (cmd_valid),
    .cmd_reg   (cmd_reg),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Registered ROM model.
  logic [15:0] rom [4];
  always @(posedge clk) rom_dout <= rom[rom_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected transaction list: command word, address, and idle (cmd_valid low) cycles before it.
  logic [15:0] exp_cmd[$];
  int          exp_pre[$];
  int          exp_addr[$];
  int          final_gap;
  int          final_addr;

  task automatic build_model();
    int  gap;
    int  i;
    bit  stop;
    exp_cmd.delete(); exp_pre.delete(); exp_addr.delete();
    gap = 0; i = 0; stop = 0;
    while (!stop) begin
      gap += 2;  // fetch + decode of entry i
      if (rom[i] == 16'hFFFF) begin
        final_gap = gap; final_addr = i; stop = 1;
      end else begin
        if (rom[i] == 16'hFFF0) begin
          gap += D_CYC;
        end else begin
          exp_cmd.push_back(rom[i]); exp_pre.push_back(gap); exp_addr.push_back(i);
          gap = 0;
        end
        if (i == LAST) begin
          final_gap = gap; final_addr = i; stop = 1;
        end else begin
          i++;
        end
      end
    end
  endtask

  bit armed    = 0;
  bit finished = 0;
  int idx      = 0;
  int gap      = 0;

  always @(negedge clk) begin
    if (armed) begin
      check("err_low", err, 0);
      if (finished) begin
        check("fin_done", done, 1);
        check("fin_busy", busy, 0);
        check("fin_valid", cmd_valid, 0);
        check("fin_addr", rom_addr, final_addr);
      end else if (idx < exp_cmd.size() && gap == exp_pre[idx]) begin
        check("cmd_valid", cmd_valid, 1);
        check("cmd_reg", cmd_reg, exp_cmd[idx][15:8]);
        check("cmd_data", cmd_data, exp_cmd[idx][7:0]);
        check("cmd_addr", rom_addr, exp_addr[idx]);
        check("run_busy", busy, 1);
        check("run_done", done, 0);
        if (cmd_valid && cmd_ready) begin
          idx++;
          gap = 0;
        end
      end else if (idx == exp_cmd.size() && gap == final_gap) begin
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_valid", cmd_valid, 0);
        check("end_addr", rom_addr, final_addr);
        finished = 1;
      end else begin
        check("gap_valid", cmd_valid, 0);
        check("gap_busy", busy, 1);
        check("gap_done", done, 0);
        gap++;
      end
    end
  end

  task automatic run_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    idx = 0; gap = 0; finished = 0; armed = 1;
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 200 && !finished; c++) @(posedge clk);
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL %s_timeout actual=not_done required=done", name);
    end
  endtask

  task automatic wait_valid(input string name);
    for (int c = 0; c < 20 && !cmd_valid; c++) @(negedge clk);
    check({name, "_valid_seen"}, cmd_valid, 1);
  endtask

  task automatic load_directed();
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
    build_model();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cmd_ready = 1'b1;
    rom[0] = '0; rom[1] = '0; rom[2] = '0; rom[3] = '0;
    #23 rst_n = 1'b1;
    @(negedge clk);
    check("rst_addr", rom_addr, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_reg", cmd_reg, 0);
    check("rst_data", cmd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // Directed table with a delay entry, model pinned by hand-derived values.
    load_directed();
    check("model_n", exp_cmd.size(), 2);
    check("model_pre0", exp_pre[0], 2);
    check("model_pre1", exp_pre[1], 2 + D_CYC + 2);
    check("model_cmd1", exp_cmd[1], 16'h1204);
    check("model_final", final_gap, 2);
    run_start();
    wait_done("directed");
    repeat (5) @(posedge clk);

    // Backpressure on entry 0.
    cmd_ready = 1'b0;
    run_start();
    wait_valid("bp");
    repeat (HOLD) @(posedge clk);
    #1 cmd_ready = 1'b1;
    wait_done("bp");
    repeat (3) @(posedge clk);

    // Table without end marker: must stop at the last address.
    rom[0] = 16'h1100; rom[1] = 16'h1201; rom[2] = 16'h1302; rom[3] = 16'h1403;
    build_model();
    check("nowrap_n", exp_cmd.size(), 4);
    check("nowrap_final", final_gap, 0);
    run_start();
    wait_done("nowrap");
    repeat (5) @(posedge clk);

    // Start mid-run is ignored; start after done re-runs the whole table.
    run_start();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("midstart");
    run_start();
    wait_done("rerun");

    // Asynchronous reset while a command is pending.
    load_directed();
    cmd_ready = 1'b0;
    run_start();
    wait_valid("rst");
    armed = 0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("arst_valid", cmd_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    cmd_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_valid", cmd_valid, 0);
      check("post_rst_addr", rom_addr, 0);
    end
    run_start();
    wait_done("after_rst");
    armed = 0;

`ifdef CFG_SEQ_TIMEOUT_EN
    begin
      int n;
      cmd_ready = 1'b0;
      run_start();
      armed = 0;
      wait_valid("to");
      n = 0;
      while (cmd_valid && n < 50) begin
        n++;
        @(negedge clk);
      end
      check("to_cycles", n, 8);
      check("to_err", err, 1);
      check("to_done", done, 1);
      check("to_busy", busy, 0);
      check("to_valid", cmd_valid, 0);
      cmd_ready = 1'b1;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
